// File: rtl/mw_sync_fifo.sv
// mw_sync_fifo
//   Single-clock FIFO that accepts up to WR_LANES entries per cycle and
//   delivers one entry per cycle through a registered, stall-gated read port.
//   Enabled write lanes are compacted in ascending lane order, so a sparse
//   enable pattern never leaves holes in storage.
//
// Optional feature (compile-time macro): FIFO_OVERFLOW_GUARD_EN
//   Defined   : a write cycle that does not fit is dropped whole, and the
//               sticky Overflow_out flag is raised until reset.
//   Undefined : no guard logic and Overflow_out is tied 0. The producer must
//               respect Full_out.
//
// Ports
//   Clk             sole clock, rising edge
//   Clear_n_in      synchronous active-low reset
//   Data_in         WR_LANES packed entries, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   WriteEn_in      per-lane write enable, any pattern
//   Full_out        free slots < WR_LANES
//   AlmostFull_out  free slots <= AFULL_MARGIN
//   Overflow_out    sticky overflow (guard build only, else 0)
//   Stall_in        blocks reads while high
//   ReadEn_in       read request
//   Data_out        registered read data, holds when no pop
//   Data_valid_out  Data_out carries a newly popped entry this cycle
//   Empty_out       count == 0
//   Count_out       occupancy 0..DEPTH
//
// Handshake: the write side has no ready; Full_out is the producer's
// back-pressure and must be honoured before the edge. On the read side a
// request (ReadEn_in) is accepted at an edge only when Stall_in is low and
// Empty_out is high-false; an accepted request shows Data_valid_out=1 with
// its entry on Data_out right after that edge. Flags and Count_out come only
// from registers.
module mw_sync_fifo #(
  parameter int DATA_WIDTH    = 65,
  parameter int ADDRESS_WIDTH = 4,
  parameter int WR_LANES      = 2,
  parameter int AFULL_MARGIN  = 2
) (
  input  logic                           Clk,
  input  logic                           Clear_n_in,
  input  logic [WR_LANES*DATA_WIDTH-1:0] Data_in,
  input  logic [WR_LANES-1:0]            WriteEn_in,
  output logic                           Full_out,
  output logic                           AlmostFull_out,
  output logic                           Overflow_out,
  input  logic                           Stall_in,
  input  logic                           ReadEn_in,
  output logic [DATA_WIDTH-1:0]          Data_out,
  output logic                           Data_valid_out,
  output logic                           Empty_out,
  output logic [ADDRESS_WIDTH:0]         Count_out
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam int CW    = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] LANES_C  = CW'(WR_LANES);
  localparam logic [CW-1:0] MARGIN_C = CW'(AFULL_MARGIN);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wp;
  logic [ADDRESS_WIDTH-1:0] rp;
  logic [CW-1:0]            count;
  logic [CW-1:0]            free_slots;
  logic [CW-1:0]            nwr;
  logic [CW-1:0]            nwr_eff;
  logic [ADDRESS_WIDTH-1:0] lane_off [WR_LANES];
  logic [WR_LANES-1:0]      wr_en_eff;
  logic                     rd;
  logic                     wr_ok;

  // Each enabled lane lands at wp plus the number of enabled lanes below it;
  // the running sum at the end is the number of entries written this cycle.
  always_comb begin
    nwr = '0;
    for (int k = 0; k < WR_LANES; k++) begin
      lane_off[k] = ADDRESS_WIDTH'(nwr);
      nwr         = nwr + CW'(WriteEn_in[k]);
    end
  end

  assign free_slots     = DEPTH_C - count;
  assign Empty_out      = (count == '0);
  assign Full_out       = (free_slots < LANES_C);
  assign AlmostFull_out = (free_slots <= MARGIN_C);
  assign Count_out      = count;

  // Reads use pre-edge state, so an entry written this cycle is not poppable.
  assign rd = ReadEn_in & ~Stall_in & ~Empty_out;

`ifdef FIFO_OVERFLOW_GUARD_EN
  logic ovf_q;

  // The slot freed by a same-cycle pop counts as room for this cycle's writes.
  assign wr_ok = ({1'b0, nwr} <= ({1'b0, free_slots} + {{CW{1'b0}}, rd}));

  always_ff @(posedge Clk) begin
    if (!Clear_n_in)
      ovf_q <= 1'b0;
    else if (!wr_ok)
      ovf_q <= 1'b1;
  end

  assign Overflow_out = ovf_q;
`else
  assign wr_ok        = 1'b1;
  assign Overflow_out = 1'b0;
`endif

  assign wr_en_eff = wr_ok ? WriteEn_in : '0;
  assign nwr_eff   = wr_ok ? nwr : '0;

  // Storage is not reset; pointers reset instead, so stale contents are
  // never visible.
  always_ff @(posedge Clk) begin
    if (Clear_n_in) begin
      for (int k = 0; k < WR_LANES; k++) begin
        if (wr_en_eff[k])
          mem[wp + lane_off[k]] <= Data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clear_n_in) begin
      wp             <= '0;
      rp             <= '0;
      count          <= '0;
      Data_out       <= '0;
      Data_valid_out <= 1'b0;
    end else begin
      wp             <= wp + ADDRESS_WIDTH'(nwr_eff);
      count          <= count + nwr_eff - CW'(rd);
      Data_valid_out <= rd;
      if (rd) begin
        Data_out <= mem[rp];
        rp       <= rp + ADDRESS_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mw_sync_fifo.sv
module tb_mw_sync_fifo;

  localparam int DW    = 65;
  localparam int AW    = 4;
  localparam int WL    = 2;
  localparam int AFM   = 2;
  localparam int DEPTH = 16;

  // ---------------- clock / reset block ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic              Clear_n_in;
  logic [WL*DW-1:0]  Data_in;
  logic [WL-1:0]     WriteEn_in;
  logic              Full_out;
  logic              AlmostFull_out;
  logic              Overflow_out;
  logic              Stall_in;
  logic              ReadEn_in;
  logic [DW-1:0]     Data_out;
  logic              Data_valid_out;
  logic              Empty_out;
  logic [AW:0]       Count_out;

  mw_sync_fifo #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WR_LANES(WL), .AFULL_MARGIN(AFM)
  ) dut (
    .Clk(Clk), .Clear_n_in(Clear_n_in), .Data_in(Data_in), .WriteEn_in(WriteEn_in),
    .Full_out(Full_out), .AlmostFull_out(AlmostFull_out), .Overflow_out(Overflow_out),
    .Stall_in(Stall_in), .ReadEn_in(ReadEn_in), .Data_out(Data_out),
    .Data_valid_out(Data_valid_out), .Empty_out(Empty_out), .Count_out(Count_out)
  );

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout = '0;
  logic          exp_dv   = 1'b0;
  logic          exp_ovf  = 1'b0;

  function automatic logic [DW-1:0] rnd_data();
    return {1'($urandom_range(0, 1)), $urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  // Applies one cycle of inputs, advances the queue model by the FIFO rules,
  // then waits until 1 time unit after the edge.
  task automatic drive_cycle(input logic clr, input logic [1:0] wen,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input logic ren, input logic stall);
    int sz;
    int nwr;
    logic pop;
    logic [1:0] wen_eff;
    Clear_n_in = clr;
    WriteEn_in = wen;
    Data_in    = {d1, d0};
    ReadEn_in  = ren;
    Stall_in   = stall;
    if (!clr) begin
      exp_q.delete();
      exp_dout = '0;
      exp_dv   = 1'b0;
      exp_ovf  = 1'b0;
    end else begin
      sz      = exp_q.size();
      nwr     = int'(wen[0]) + int'(wen[1]);
      pop     = ren && !stall && (sz != 0);
      wen_eff = wen;
      exp_dv  = pop;
      if (pop) exp_dout = exp_q.pop_front();
`ifdef FIFO_OVERFLOW_GUARD_EN
      if (nwr > DEPTH - sz + int'(pop)) begin
        wen_eff = 2'b00;
        exp_ovf = 1'b1;
      end
`endif
      if (wen_eff[0]) exp_q.push_back(d0);
      if (wen_eff[1]) exp_q.push_back(d1);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic fill_to(input int n);
    while (exp_q.size() < n) begin
      if (n - exp_q.size() >= 2) drive_cycle(1'b1, 2'b11, rnd_data(), rnd_data(), 1'b0, 1'b0);
      else                       drive_cycle(1'b1, 2'b01, rnd_data(), '0, 1'b0, 1'b0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_cycle(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    drive_cycle(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    idle_cycle();
    total++; if (Empty_out !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", Empty_out); end
    total++; if (Count_out !== 5'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", Count_out); end
    total++; if (Data_valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", Data_valid_out); end
    total++; if (Data_out !== '0) begin bad++; $display("FAIL rst_data: got %0h want 0", Data_out); end
    total++; if (Full_out !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", Full_out); end
    total++; if (AlmostFull_out !== 1'b0) begin bad++; $display("FAIL rst_afull: got %b want 0", AlmostFull_out); end
    total++; if (Overflow_out !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", Overflow_out); end
  endtask

  task automatic test_sparse_order();
    logic [DW-1:0] a, b, c;
    logic [DW-1:0] want [3];
    a = rnd_data(); b = rnd_data(); c = rnd_data();
    want[0] = a; want[1] = b; want[2] = c;
    drive_cycle(1'b1, 2'b11, a, b, 1'b0, 1'b0);
    drive_cycle(1'b1, 2'b10, rnd_data(), c, 1'b0, 1'b0);
    total++; if (Count_out !== 5'd3) begin bad++; $display("FAIL sparse_count: got %0d want 3", Count_out); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 2'b00, '0, '0, 1'b1, 1'b0);
      total++; if (Data_valid_out !== 1'b1) begin bad++; $display("FAIL sparse_valid%0d: got %b want 1", i, Data_valid_out); end
      total++; if (Data_out !== want[i]) begin bad++; $display("FAIL sparse_data%0d: got %0h want %0h", i, Data_out, want[i]); end
      total++; if (Count_out !== 5'(2 - i)) begin bad++; $display("FAIL sparse_cnt%0d: got %0d want %0d", i, Count_out, 2 - i); end
    end
    total++; if (Empty_out !== 1'b1) begin bad++; $display("FAIL sparse_empty: got %b want 1", Empty_out); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 14; i += 2)
      drive_cycle(1'b1, 2'b11, DW'(i), DW'(i + 1), 1'b0, 1'b0);
    total++; if (Full_out !== 1'b0 || AlmostFull_out !== 1'b1) begin bad++; $display("FAIL fill14_flags: got full=%b afull=%b want 0/1", Full_out, AlmostFull_out); end
    drive_cycle(1'b1, 2'b01, DW'(14), '0, 1'b0, 1'b0);
    total++; if (Count_out !== 5'd15) begin bad++; $display("FAIL fill15_count: got %0d want 15", Count_out); end
    total++; if (Full_out !== 1'b1) begin bad++; $display("FAIL fill15_full: got %b want 1", Full_out); end
    drive_cycle(1'b1, 2'b01, DW'(15), '0, 1'b0, 1'b0);
    total++; if (Count_out !== 5'd16 || Full_out !== 1'b1) begin bad++; $display("FAIL fill16: got count=%0d full=%b want 16/1", Count_out, Full_out); end
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 2'b00, '0, '0, 1'b1, 1'b0);
      total++; if (Data_valid_out !== 1'b1 || Data_out !== DW'(i)) begin bad++; $display("FAIL wrap_pop%0d: got v=%b d=%0h want 1/%0h", i, Data_valid_out, Data_out, i); end
    end
    for (int i = 16; i < 24; i += 2)
      drive_cycle(1'b1, 2'b11, DW'(i), DW'(i + 1), 1'b0, 1'b0);
    total++; if (Count_out !== 5'd16) begin bad++; $display("FAIL wrap_refill: got %0d want 16", Count_out); end
    for (int i = 8; i < 24; i++) begin
      drive_cycle(1'b1, 2'b00, '0, '0, 1'b1, 1'b0);
      total++; if (Data_valid_out !== 1'b1 || Data_out !== DW'(i)) begin bad++; $display("FAIL wrap_drain%0d: got v=%b d=%0h want 1/%0h", i, Data_valid_out, Data_out, i); end
    end
    total++; if (Empty_out !== 1'b1) begin bad++; $display("FAIL wrap_empty: got %b want 1", Empty_out); end
  endtask

  task automatic test_concurrent_stall();
    logic [DW-1:0] held;
    fill_to(5);
    drive_cycle(1'b1, 2'b11, rnd_data(), rnd_data(), 1'b1, 1'b0);
    total++; if (Count_out !== 5'd6) begin bad++; $display("FAIL conc_count: got %0d want 6", Count_out); end
    total++; if (Data_valid_out !== 1'b1 || Data_out !== exp_dout) begin bad++; $display("FAIL conc_data: got v=%b d=%0h want 1/%0h", Data_valid_out, Data_out, exp_dout); end
    held = exp_dout;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 2'b00, '0, '0, 1'b1, 1'b1);
      total++; if (Data_valid_out !== 1'b0 || Count_out !== 5'd6) begin bad++; $display("FAIL stall%0d: got v=%b cnt=%0d want 0/6", i, Data_valid_out, Count_out); end
      total++; if (Data_out !== held) begin bad++; $display("FAIL stall_hold%0d: got %0h want %0h", i, Data_out, held); end
    end
    drive_cycle(1'b1, 2'b11, rnd_data(), rnd_data(), 1'b1, 1'b1);
    total++; if (Count_out !== 5'd8 || Data_valid_out !== 1'b0) begin bad++; $display("FAIL stall_write: got cnt=%0d v=%b want 8/0", Count_out, Data_valid_out); end
    drive_cycle(1'b1, 2'b00, '0, '0, 1'b1, 1'b0);
    total++; if (Data_valid_out !== 1'b1 || Data_out !== exp_dout) begin bad++; $display("FAIL unstall: got v=%b d=%0h want 1/%0h", Data_valid_out, Data_out, exp_dout); end
  endtask

`ifdef FIFO_OVERFLOW_GUARD_EN
  task automatic test_overflow();
    drive_cycle(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    fill_to(15);
    drive_cycle(1'b1, 2'b11, rnd_data(), rnd_data(), 1'b0, 1'b0);
    total++; if (Count_out !== 5'd15) begin bad++; $display("FAIL ovf_count: got %0d want 15", Count_out); end
    total++; if (Overflow_out !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", Overflow_out); end
    idle_cycle();
    total++; if (Overflow_out !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", Overflow_out); end
    for (int i = 0; i < 15; i++) begin
      drive_cycle(1'b1, 2'b00, '0, '0, 1'b1, 1'b0);
      total++; if (Data_out !== exp_dout) begin bad++; $display("FAIL ovf_drain%0d: got %0h want %0h", i, Data_out, exp_dout); end
    end
    drive_cycle(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    total++; if (Overflow_out !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", Overflow_out); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [DW-1:0] z;
    fill_to(6);
    drive_cycle(1'b0, 2'b11, rnd_data(), rnd_data(), 1'b1, 1'b0);
    total++; if (Count_out !== 5'd0 || Empty_out !== 1'b1) begin bad++; $display("FAIL midrst_state: got cnt=%0d empty=%b want 0/1", Count_out, Empty_out); end
    total++; if (Data_valid_out !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", Data_valid_out); end
    drive_cycle(1'b1, 2'b00, '0, '0, 1'b1, 1'b0);
    total++; if (Data_valid_out !== 1'b0 || Count_out !== 5'd0) begin bad++; $display("FAIL midrst_nopop: got v=%b cnt=%0d want 0/0", Data_valid_out, Count_out); end
    z = rnd_data();
    drive_cycle(1'b1, 2'b01, z, '0, 1'b1, 1'b0);
    total++; if (Data_valid_out !== 1'b0 || Count_out !== 5'd1) begin bad++; $display("FAIL midrst_wr: got v=%b cnt=%0d want 0/1", Data_valid_out, Count_out); end
    drive_cycle(1'b1, 2'b00, '0, '0, 1'b1, 1'b0);
    total++; if (Data_valid_out !== 1'b1 || Data_out !== z) begin bad++; $display("FAIL midrst_data: got v=%b d=%0h want 1/%0h", Data_valid_out, Data_out, z); end
  endtask

  task automatic test_random();
    logic [1:0] wen;
    int sz;
    for (int i = 0; i < 600; i++) begin
      wen = 2'($urandom_range(0, 3));
      sz  = exp_q.size();
`ifndef FIFO_OVERFLOW_GUARD_EN
      if (DEPTH - sz < WL) wen = 2'b00;
`endif
      drive_cycle(($urandom_range(0, 99) != 0), wen, rnd_data(), rnd_data(),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      sz = exp_q.size();
      total++; if (Data_valid_out !== exp_dv) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", i, Data_valid_out, exp_dv); end
      total++; if (Data_out !== exp_dout) begin bad++; $display("FAIL rnd_data@%0d: got %0h want %0h", i, Data_out, exp_dout); end
      total++; if (Count_out !== 5'(sz)) begin bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, Count_out, sz); end
      total++; if (Empty_out !== (sz == 0)) begin bad++; $display("FAIL rnd_empty@%0d: got %b want %b", i, Empty_out, sz == 0); end
      total++; if (Full_out !== (DEPTH - sz < WL)) begin bad++; $display("FAIL rnd_full@%0d: got %b want %b", i, Full_out, DEPTH - sz < WL); end
      total++; if (AlmostFull_out !== (DEPTH - sz <= AFM)) begin bad++; $display("FAIL rnd_afull@%0d: got %b want %b", i, AlmostFull_out, DEPTH - sz <= AFM); end
      total++; if (Overflow_out !== exp_ovf) begin bad++; $display("FAIL rnd_ovf@%0d: got %b want %b", i, Overflow_out, exp_ovf); end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    Clear_n_in = 1'b0;
    WriteEn_in = '0;
    Data_in    = '0;
    ReadEn_in  = 1'b0;
    Stall_in   = 1'b0;
    test_reset();
    test_sparse_order();
    test_fill_wrap();
    test_concurrent_stall();
`ifdef FIFO_OVERFLOW_GUARD_EN
    test_overflow();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mw_sync_fifo.md
# mw_sync_fifo

Single-clock FIFO accepting up to WR_LANES entries per cycle and delivering one entry per cycle. It replaces the dual-clock, single-write and fixed-two-write FIFOs on paths where producer and consumer share one clock. Unlike those FIFOs, it has real occupancy tracking, meaningful Full_out/AlmostFull_out flags, sparse per-lane write enables and a stall-gated registered read port. It sits between the multi-result pipeline stages and the single-issue output/consumer stage.

## Interface
- DATA_WIDTH, 65, width of one entry
- ADDRESS_WIDTH, 4, log2 of depth; DEPTH = 1 << ADDRESS_WIDTH
- WR_LANES, 2, write lanes per cycle; legal range 1..DEPTH
- AFULL_MARGIN, 2, AlmostFull_out asserts when free slots <= AFULL_MARGIN

Ports:
- Clk  in  1  sole clock, all logic on rising edge
- Clear_n_in  in  1  reset, synchronous, active-low
- Data_in  in  WR_LANES*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- WriteEn_in  in  WR_LANES  per-lane write enable; any bit pattern is legal
- Full_out  out  1  free slots < WR_LANES
- AlmostFull_out  out  1  free slots <= AFULL_MARGIN
- Overflow_out  out  1  sticky overflow flag; present only with FIFO_OVERFLOW_GUARD_EN, else tied 0
- Stall_in  in  1  blocks reads while high
- ReadEn_in  in  1  read request
- Data_out  out  DATA_WIDTH  registered read data
- Data_valid_out  out  1  Data_out carries a newly popped entry this cycle
- Empty_out  out  1  count == 0
- Count_out  out  ADDRESS_WIDTH+1  occupancy, 0..DEPTH

## Operation
- **Storage:** DEPTH x DATA_WIDTH register array; contents not reset. Write pointer, read pointer and count are binary. Pointers are ADDRESS_WIDTH bits and wrap modulo DEPTH.
- **Write:** nwr = popcount(WriteEn_in). Enabled lanes are compacted in ascending lane order into addresses wp, wp+1, … wp+nwr-1 (mod DEPTH). wp advances by nwr. Example: WriteEn_in=2'b10 writes lane 1 at wp.
- **Read:** rd = ReadEn_in & ~Stall_in & ~Empty_out. On rd, Data_out <= mem[rp], Data_valid_out <= 1 and rp advances. Otherwise Data_valid_out <= 0 and Data_out holds its value.
- **Count:** count_next = count + nwr - rd, computed in ADDRESS_WIDTH+1 bits. Flags are derived from the count register: Empty_out = (count==0), Full_out = (DEPTH-count < WR_LANES), AlmostFull_out = (DEPTH-count <= AFULL_MARGIN).
- **Simultaneous read and write:** always legal. A read uses pre-edge state, so a write to an empty FIFO is not readable in the same cycle.
- **Reset** (Clear_n_in=0 at an edge) takes priority over all activity, including mid-burst. Result: wp=rp=0, count=0, Data_out=0, Data_valid_out=0, Empty_out=1, Full_out=0 (since WR_LANES<=DEPTH), AlmostFull_out=(DEPTH<=AFULL_MARGIN), Overflow_out=0.

## Timing
- Write-to-readable latency: 1 cycle. An entry written at edge t gives Empty_out=0 after t, and it can be popped at edge t+1.
- Read latency: 1 cycle. The request is sampled at edge t; Data_out and Data_valid_out are valid immediately after edge t.
- Maximum throughput: 1 read per cycle and WR_LANES writes per cycle.
- Flags and Count_out are registered outputs, with no combinational path from inputs.
- Stall_in affects only the read side. Writes proceed during a stall.

## Configuration
- **FIFO_OVERFLOW_GUARD_EN defined:**
  - A cycle with nwr > DEPTH-count+rd is rejected whole: no entry written, wp and count change only by the read.
  - Overflow_out is set and stays high until reset.
- **Undefined:**
  - No guard logic; Overflow_out is tied 0.
  - The producer must not write when Full_out=1. Writing past capacity corrupts contents and count, and no recovery is provided except reset.

## Test plan
- **Reset then idle:** Clear_n_in=0 for 2 cycles, then 1 -> Empty_out=1, Count_out=0, Data_valid_out=0, Data_out=0, Full_out=0.
- **Sparse-lane ordering:** WR_LANES=2. Cycle 1 writes A/B with WriteEn_in=2'b11. Cycle 2 writes C on lane 1 only (WriteEn_in=2'b10). Then ReadEn_in=1 for 3 cycles -> Data_out sequence A, B, C with Data_valid_out=1 on each; Count_out goes 3,2,1,0; Empty_out=1 after the third pop.
- **Fill and wrap:** DEPTH=16. Write 16 entries 0x00..0x0F -> Full_out=1 at count 15. Pop 8, write 0x10..0x17, then drain -> data order 0x08..0x17 with no gaps or repeats, confirming pointer wrap.
- **Concurrent read/write and stall:** At count 5, WriteEn_in=2'b11 with ReadEn_in=1 -> Count_out=6. Raising Stall_in with ReadEn_in=1 -> Data_valid_out=0 and Count_out unchanged while stalled.
- **Overflow (macro defined):** At count 15, write 2 lanes with no read -> write rejected, Count_out stays 15, Overflow_out=1 and sticky. Clear_n_in=0 -> Overflow_out=0.
- **Reset mid-operation:** Reset asserted during a concurrent 2-lane write and read -> next cycle Count_out=0, Empty_out=1, Data_valid_out=0, and none of the in-flight data appears afterward.
